// File: rtl/hazard_scoreboard_if.sv
// Pipeline-facing bundle for the hazard/forwarding controller: per-stage
// instruction info toward the controller, stall/flush/forward controls and status back.
interface hazard_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LONG   = 4,
  parameter int CNT_W      = 32
);
  localparam int AW = $clog2(DATA_WIDTH);
  localparam int LW = $clog2(MAX_LONG + 1);

  logic             id_valid;
  logic             id_need_rs1;
  logic             id_need_rs2;
  logic             id_reg_write;
  logic             id_is_long;
  logic [AW-1:0]    id_rs1_addr;
  logic [AW-1:0]    id_rs2_addr;
  logic [AW-1:0]    id_rd_addr;

  logic [AW-1:0]    ex_rs1_addr;
  logic [AW-1:0]    ex_rs2_addr;
  logic [AW-1:0]    ex_rd_addr;
  logic             ex_need_rs1;
  logic             ex_need_rs2;
  logic             ex_reg_write;
  logic             ex_is_load;
  logic             ex_is_csr;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic             ex_br_taken;
  logic             ex_is_mret;

  logic [AW-1:0]    mem_rd_addr;
  logic [AW-1:0]    wb_rd_addr;
  logic             mem_reg_write;
  logic             wb_reg_write;

  logic             long_done;
  logic [AW-1:0]    long_done_rd;
  logic             mem_stall;
  logic             trap_commit;
  logic             mret_commit;

  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             stall_pc;
  logic             stall_if_id;
  logic             stall_id_ex;
  logic             stall_ex_mem;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic             flush_mem_wb;
  logic             pc_sel;
  logic [2:0]       hazard_cause;
  logic [LW-1:0]    long_busy_count;
  logic [CNT_W-1:0] perf_stall_cycles;
  logic [CNT_W-1:0] perf_flushes;

  modport master (
    output id_valid, id_need_rs1, id_need_rs2, id_reg_write, id_is_long,
           id_rs1_addr, id_rs2_addr, id_rd_addr,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_need_rs1, ex_need_rs2,
           ex_reg_write, ex_is_load, ex_is_csr, ex_is_branch, ex_is_jump,
           ex_br_taken, ex_is_mret,
           mem_rd_addr, wb_rd_addr, mem_reg_write, wb_reg_write,
           long_done, long_done_rd, mem_stall, trap_commit, mret_commit,
    input  fwd_a, fwd_b, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, pc_sel,
           hazard_cause, long_busy_count, perf_stall_cycles, perf_flushes
  );

  modport slave (
    input  id_valid, id_need_rs1, id_need_rs2, id_reg_write, id_is_long,
           id_rs1_addr, id_rs2_addr, id_rd_addr,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_need_rs1, ex_need_rs2,
           ex_reg_write, ex_is_load, ex_is_csr, ex_is_branch, ex_is_jump,
           ex_br_taken, ex_is_mret,
           mem_rd_addr, wb_rd_addr, mem_reg_write, wb_reg_write,
           long_done, long_done_rd, mem_stall, trap_commit, mret_commit,
    output fwd_a, fwd_b, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, pc_sel,
           hazard_cause, long_busy_count, perf_stall_cycles, perf_flushes
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller for the 5-stage pipeline: long-op register scoreboard,
// trap/mret flush sequencing around cache misses, and saturating stall/flush counters.
module hazard_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LONG   = 4,
  parameter int CNT_W      = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_scoreboard_if.slave bus
);
  localparam int AW = $clog2(DATA_WIDTH);
  localparam int LW = $clog2(MAX_LONG + 1);
  localparam logic [LW-1:0]         LONG_FULL = LW'(MAX_LONG);
  localparam logic [LW-1:0]         LONG_ZERO = {LW{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [AW-1:0]         REG_ZERO  = {AW{1'b0}};
  localparam logic [DATA_WIDTH-1:0] BIT_ONE   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } flush_state_e;

  flush_state_e          state_r, state_s;
  logic [DATA_WIDTH-1:0] busy_r, busy_s;
  logic [LW-1:0]         count_r, count_s;
  logic [CNT_W-1:0]      perf_stall_r, perf_flush_r;

  logic                  commit_s, trap_flush_s, mem_hold_s;
  logic                  sb_hazard_s, load_use_s, csr_use_s, branch_s;
  logic                  id_reads_ex_rd_s, issue_s, done_s;
  logic [DATA_WIDTH-1:0] set_mask_s, clr_mask_s;

  function automatic logic [1:0] fwd_select(
    input logic          need,
    input logic [AW-1:0] src,
    input logic          mem_we,
    input logic [AW-1:0] mem_rd,
    input logic          wb_we,
    input logic [AW-1:0] wb_rd
  );
    logic [1:0] sel;
    if (need && mem_we && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
      sel = 2'b10;
    end else if (need && wb_we && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard condition decode from ID/EX info and the current scoreboard state
  always_comb begin
    commit_s     = bus.trap_commit | bus.mret_commit;
    trap_flush_s = (state_r == ST_FLUSH) ||
                   ((state_r == ST_RUN) && commit_s && !bus.mem_stall);
    mem_hold_s   = bus.mem_stall || (state_r == ST_DRAIN);
    sb_hazard_s  = bus.id_valid && (
                     (bus.id_need_rs1 && (bus.id_rs1_addr != REG_ZERO) && busy_r[bus.id_rs1_addr]) ||
                     (bus.id_need_rs2 && (bus.id_rs2_addr != REG_ZERO) && busy_r[bus.id_rs2_addr]) ||
                     (bus.id_reg_write && busy_r[bus.id_rd_addr]) ||
                     (bus.id_is_long && (count_r == LONG_FULL)));
    id_reads_ex_rd_s = (bus.ex_rd_addr != REG_ZERO) && (
                         (bus.id_need_rs1 && (bus.id_rs1_addr == bus.ex_rd_addr)) ||
                         (bus.id_need_rs2 && (bus.id_rs2_addr == bus.ex_rd_addr)));
    load_use_s   = bus.ex_is_load && id_reads_ex_rd_s;
    csr_use_s    = bus.ex_is_csr && bus.ex_reg_write && id_reads_ex_rd_s;
    branch_s     = (bus.ex_is_branch && bus.ex_br_taken) || bus.ex_is_jump;
  end

  // Priority chain: first matching cause owns every stall/flush/redirect control
  always_comb begin
    bus.stall_pc     = 1'b0;
    bus.stall_if_id  = 1'b0;
    bus.stall_id_ex  = 1'b0;
    bus.stall_ex_mem = 1'b0;
    bus.flush_if_id  = 1'b0;
    bus.flush_id_ex  = 1'b0;
    bus.flush_ex_mem = 1'b0;
    bus.flush_mem_wb = 1'b0;
    bus.pc_sel       = 1'b0;
    bus.hazard_cause = 3'd0;
    if (trap_flush_s) begin
      bus.flush_if_id  = 1'b1;
      bus.flush_id_ex  = 1'b1;
      bus.flush_ex_mem = 1'b1;
      bus.flush_mem_wb = 1'b1;
      bus.hazard_cause = 3'd1;
    end else if (mem_hold_s) begin
      bus.stall_pc     = 1'b1;
      bus.stall_if_id  = 1'b1;
      bus.stall_id_ex  = 1'b1;
      bus.stall_ex_mem = 1'b1;
      bus.flush_mem_wb = bus.mem_stall;
      bus.hazard_cause = 3'd2;
    end else if (sb_hazard_s || load_use_s || csr_use_s) begin
      bus.stall_pc     = 1'b1;
      bus.stall_if_id  = 1'b1;
      bus.flush_id_ex  = 1'b1;
      bus.hazard_cause = sb_hazard_s ? 3'd3 : (load_use_s ? 3'd4 : 3'd5);
    end else if (branch_s) begin
      bus.pc_sel       = 1'b1;
      bus.flush_if_id  = 1'b1;
      bus.flush_id_ex  = 1'b1;
      bus.hazard_cause = 3'd6;
    end else if (bus.ex_is_mret) begin
      bus.flush_if_id  = 1'b1;
      bus.flush_id_ex  = 1'b1;
      bus.hazard_cause = 3'd7;
    end else begin
      bus.hazard_cause = 3'd0;
    end
  end

  assign bus.fwd_a = fwd_select(bus.ex_need_rs1, bus.ex_rs1_addr, bus.mem_reg_write,
                                bus.mem_rd_addr, bus.wb_reg_write, bus.wb_rd_addr);
  assign bus.fwd_b = fwd_select(bus.ex_need_rs2, bus.ex_rs2_addr, bus.mem_reg_write,
                                bus.mem_rd_addr, bus.wb_reg_write, bus.wb_rd_addr);

  // Scoreboard next state; a trap flush wipes it, and issue beats completion on the same rd
  always_comb begin
    issue_s    = bus.id_valid && bus.id_is_long && bus.id_reg_write &&
                 (bus.id_rd_addr != REG_ZERO) && !bus.stall_if_id && !bus.flush_id_ex;
    done_s     = bus.long_done && (count_r != LONG_ZERO);
    set_mask_s = issue_s ? (BIT_ONE << bus.id_rd_addr)   : {DATA_WIDTH{1'b0}};
    clr_mask_s = done_s  ? (BIT_ONE << bus.long_done_rd) : {DATA_WIDTH{1'b0}};
    if (trap_flush_s) begin
      busy_s  = {DATA_WIDTH{1'b0}};
      count_s = LONG_ZERO;
    end else begin
      busy_s = (busy_r & ~clr_mask_s) | set_mask_s;
      case ({issue_s, done_s})
        2'b10:   count_s = count_r + LW'(1);
        2'b01:   count_s = count_r - LW'(1);
        default: count_s = count_r;
      endcase
    end
  end

  // Flush sequencer: a commit during a miss waits in DRAIN, then flushes once
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RUN:   state_s = (commit_s && bus.mem_stall) ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_s = bus.mem_stall ? ST_DRAIN : ST_FLUSH;
      ST_FLUSH: state_s = ST_RUN;
      default:  state_s = ST_RUN;
    endcase
  end

  // State registers and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_RUN;
      busy_r       <= {DATA_WIDTH{1'b0}};
      count_r      <= LONG_ZERO;
      perf_stall_r <= {CNT_W{1'b0}};
      perf_flush_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      count_r <= count_s;
      if (bus.stall_pc && (perf_stall_r != CNT_MAX)) begin
        perf_stall_r <= perf_stall_r + CNT_W'(1);
      end
      if (bus.flush_id_ex && (perf_flush_r != CNT_MAX)) begin
        perf_flush_r <= perf_flush_r + CNT_W'(1);
      end
    end
  end

  assign bus.long_busy_count   = count_r;
  assign bus.perf_stall_cycles = perf_stall_r;
  assign bus.perf_flushes      = perf_flush_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: directed plan scenarios then random traffic, each cycle's expected
// controls predicted by a rule-level model and checked by an independent monitor.
module tb_hazard_scoreboard;
  localparam int DW   = 32;
  localparam int ML   = 2;
  localparam int CW   = 4;
  localparam int AW   = $clog2(DW);
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.DATA_WIDTH(DW), .MAX_LONG(ML), .CNT_W(CW)) hif ();
  hazard_scoreboard #(.DATA_WIDTH(DW), .MAX_LONG(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(hif)
  );

  typedef struct {
    bit rst;
    bit id_valid, id_need_rs1, id_need_rs2, id_reg_write, id_is_long;
    int id_rs1, id_rs2, id_rd;
    int ex_rs1, ex_rs2, ex_rd;
    bit ex_need_rs1, ex_need_rs2, ex_reg_write, ex_is_load, ex_is_csr;
    bit ex_is_branch, ex_is_jump, ex_br_taken, ex_is_mret;
    int mem_rd, wb_rd;
    bit mem_reg_write, wb_reg_write;
    bit long_done;
    int long_done_rd;
    bit mem_stall, trap_commit, mret_commit;
  } stim_t;

  typedef struct {
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stalls;   // pc, if_id, id_ex, ex_mem
    logic [3:0] flushes;  // if_id, id_ex, ex_mem, mem_wb
    logic       pc_sel;
    logic [2:0] cause;
    int         count, perf_s, perf_f;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference model: set of busy registers, in-flight count, pending-trap bookkeeping
  bit busy_m[DW];
  int inflight_m, pstall_m, pflush_m;
  bit draining_m, flush_due_m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    inflight_m = 0; pstall_m = 0; pflush_m = 0;
    draining_m = 1'b0; flush_due_m = 1'b0;
  endfunction

  function automatic logic [1:0] fwd_exp(bit need, int src, bit mwe, int mrd, bit wwe, int wrd);
    if (need && mwe && mrd != 0 && mrd == src) return 2'b10;
    if (need && wwe && wrd != 0 && wrd == src) return 2'b11;
    return 2'b00;
  endfunction

  function automatic exp_t predict(stim_t s);
    exp_t e;
    bit commit, trapf, hold, sb, hits, lu, cu, br;
    commit = s.trap_commit || s.mret_commit;
    trapf  = flush_due_m || (!draining_m && commit && !s.mem_stall);
    hold   = s.mem_stall || draining_m;
    sb     = s.id_valid && ((s.id_need_rs1 && s.id_rs1 != 0 && busy_m[s.id_rs1]) ||
                            (s.id_need_rs2 && s.id_rs2 != 0 && busy_m[s.id_rs2]) ||
                            (s.id_reg_write && busy_m[s.id_rd]) ||
                            (s.id_is_long && inflight_m == ML));
    hits   = s.ex_rd != 0 && ((s.id_need_rs1 && s.id_rs1 == s.ex_rd) ||
                              (s.id_need_rs2 && s.id_rs2 == s.ex_rd));
    lu = s.ex_is_load && hits;
    cu = s.ex_is_csr && s.ex_reg_write && hits;
    br = (s.ex_is_branch && s.ex_br_taken) || s.ex_is_jump;
    if (trapf)           e.cause = 3'd1;
    else if (hold)       e.cause = 3'd2;
    else if (sb)         e.cause = 3'd3;
    else if (lu)         e.cause = 3'd4;
    else if (cu)         e.cause = 3'd5;
    else if (br)         e.cause = 3'd6;
    else if (s.ex_is_mret) e.cause = 3'd7;
    else                 e.cause = 3'd0;
    e.stalls = 4'b0000; e.flushes = 4'b0000; e.pc_sel = 1'b0;
    case (e.cause)
      3'd1:             e.flushes = 4'b1111;
      3'd2:             begin e.stalls = 4'b1111; e.flushes = s.mem_stall ? 4'b0001 : 4'b0000; end
      3'd3, 3'd4, 3'd5: begin e.stalls = 4'b1100; e.flushes = 4'b0100; end
      3'd6:             begin e.flushes = 4'b1100; e.pc_sel = 1'b1; end
      3'd7:             e.flushes = 4'b1100;
      default:          e.flushes = 4'b0000;
    endcase
    e.fwd_a  = fwd_exp(s.ex_need_rs1, s.ex_rs1, s.mem_reg_write, s.mem_rd, s.wb_reg_write, s.wb_rd);
    e.fwd_b  = fwd_exp(s.ex_need_rs2, s.ex_rs2, s.mem_reg_write, s.mem_rd, s.wb_reg_write, s.wb_rd);
    e.count  = inflight_m;
    e.perf_s = pstall_m;
    e.perf_f = pflush_m;
    return e;
  endfunction

  function automatic void update(stim_t s, exp_t e);
    bit issue, done;
    if (s.rst) begin
      model_reset();
      return;
    end
    if (e.stalls[3])  pstall_m = (pstall_m < CMAX) ? pstall_m + 1 : CMAX;
    if (e.flushes[2]) pflush_m = (pflush_m < CMAX) ? pflush_m + 1 : CMAX;
    if (e.cause == 3'd1) begin
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      inflight_m = 0;
    end else begin
      issue = s.id_valid && s.id_is_long && s.id_reg_write && s.id_rd != 0 &&
              !e.stalls[2] && !e.flushes[2];
      done  = s.long_done && inflight_m > 0;
      if (done)  busy_m[s.long_done_rd] = 1'b0;
      if (issue) busy_m[s.id_rd] = 1'b1;
      inflight_m = inflight_m + int'(issue) - int'(done);
    end
    if (flush_due_m) flush_due_m = 1'b0;
    else if (draining_m) begin
      if (!s.mem_stall) begin draining_m = 1'b0; flush_due_m = 1'b1; end
    end else if ((s.trap_commit || s.mret_commit) && s.mem_stall) draining_m = 1'b1;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst               = s.rst;
    hif.id_valid      = s.id_valid;     hif.id_need_rs1  = s.id_need_rs1;
    hif.id_need_rs2   = s.id_need_rs2;  hif.id_reg_write = s.id_reg_write;
    hif.id_is_long    = s.id_is_long;
    hif.id_rs1_addr   = AW'(s.id_rs1);  hif.id_rs2_addr  = AW'(s.id_rs2);
    hif.id_rd_addr    = AW'(s.id_rd);
    hif.ex_rs1_addr   = AW'(s.ex_rs1);  hif.ex_rs2_addr  = AW'(s.ex_rs2);
    hif.ex_rd_addr    = AW'(s.ex_rd);
    hif.ex_need_rs1   = s.ex_need_rs1;  hif.ex_need_rs2  = s.ex_need_rs2;
    hif.ex_reg_write  = s.ex_reg_write; hif.ex_is_load   = s.ex_is_load;
    hif.ex_is_csr     = s.ex_is_csr;    hif.ex_is_branch = s.ex_is_branch;
    hif.ex_is_jump    = s.ex_is_jump;   hif.ex_br_taken  = s.ex_br_taken;
    hif.ex_is_mret    = s.ex_is_mret;
    hif.mem_rd_addr   = AW'(s.mem_rd);  hif.wb_rd_addr   = AW'(s.wb_rd);
    hif.mem_reg_write = s.mem_reg_write; hif.wb_reg_write = s.wb_reg_write;
    hif.long_done     = s.long_done;    hif.long_done_rd = AW'(s.long_done_rd);
    hif.mem_stall     = s.mem_stall;    hif.trap_commit  = s.trap_commit;
    hif.mret_commit   = s.mret_commit;
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    drive(s);
    e = predict(s);
    exp_q.push_back(e);
    update(s, e);
  endtask

  function automatic bit pct(int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic int raddr();
    return int'($urandom_range(0, 3));
  endfunction

  // Monitor: every cycle the DUT presents a full control word, checked against the queue head
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("fwd_a", int'(hif.fwd_a), int'(mon_e.fwd_a));
      chk("fwd_b", int'(hif.fwd_b), int'(mon_e.fwd_b));
      chk("stalls", int'({hif.stall_pc, hif.stall_if_id, hif.stall_id_ex, hif.stall_ex_mem}),
          int'(mon_e.stalls));
      chk("flushes", int'({hif.flush_if_id, hif.flush_id_ex, hif.flush_ex_mem, hif.flush_mem_wb}),
          int'(mon_e.flushes));
      chk("pc_sel", int'(hif.pc_sel), int'(mon_e.pc_sel));
      chk("hazard_cause", int'(hif.hazard_cause), int'(mon_e.cause));
      chk("long_busy_count", int'(hif.long_busy_count), mon_e.count);
      chk("perf_stall_cycles", int'(hif.perf_stall_cycles), mon_e.perf_s);
      chk("perf_flushes", int'(hif.perf_flushes), mon_e.perf_f);
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    drive(s);
    repeat (2) @(posedge clk);
    model_reset();
    apply(s);

    // Long op to x5, dependent reader stalls until completion, then releases
    s = idle(); s.id_valid = 1; s.id_is_long = 1; s.id_reg_write = 1; s.id_rd = 5; apply(s);
    s = idle(); s.id_valid = 1; s.id_need_rs1 = 1; s.id_rs1 = 5; s.id_reg_write = 1; s.id_rd = 6;
    repeat (3) apply(s);
    s.long_done = 1; s.long_done_rd = 5; apply(s);
    s.long_done = 0; apply(s);

    // Fill to MAX_LONG, third long op stalls, then completion with concurrent issue
    s = idle(); s.id_valid = 1; s.id_is_long = 1; s.id_reg_write = 1;
    s.id_rd = 1; apply(s);
    s.id_rd = 2; apply(s);
    s.id_rd = 3; apply(s); apply(s);
    s.long_done = 1; s.long_done_rd = 1; apply(s);
    s.long_done_rd = 2; apply(s);
    s = idle(); s.long_done = 1; s.long_done_rd = 9; apply(s);

    // Load-use then forwarding from MEM
    s = idle(); s.id_valid = 1; s.ex_is_load = 1; s.ex_rd = 7; s.id_need_rs2 = 1; s.id_rs2 = 7; apply(s);
    s.ex_is_load = 0; s.ex_rd = 0; s.ex_need_rs2 = 1; s.ex_rs2 = 7; s.mem_reg_write = 1; s.mem_rd = 7;
    apply(s);
    s.mem_reg_write = 0; s.wb_reg_write = 1; s.wb_rd = 7; s.ex_need_rs1 = 1; s.ex_rs1 = 7; apply(s);

    // Trap while the cache misses: drain, one flush, scoreboard empty afterwards
    s = idle(); s.id_valid = 1; s.id_is_long = 1; s.id_reg_write = 1; s.id_rd = 3; apply(s);
    s = idle(); s.trap_commit = 1; s.mem_stall = 1; apply(s);
    s.trap_commit = 0; apply(s); apply(s);
    s.mret_commit = 1; s.mem_stall = 0; apply(s);
    s = idle(); s.id_valid = 1; s.id_need_rs1 = 1; s.id_rs1 = 3; apply(s); apply(s);

    // Taken branch loses to load-use, then redirects; csr-use and mret-in-EX
    s = idle(); s.ex_is_branch = 1; s.ex_br_taken = 1; s.ex_is_load = 1; s.ex_rd = 9;
    s.id_need_rs1 = 1; s.id_rs1 = 9; apply(s);
    s.ex_is_load = 0; apply(s);
    s = idle(); s.ex_is_csr = 1; s.ex_reg_write = 1; s.ex_rd = 4; s.id_need_rs2 = 1; s.id_rs2 = 4; apply(s);
    s = idle(); s.ex_is_mret = 1; apply(s);

    // Counter saturation, then reset in the middle of a drain
    s = idle(); s.rst = 1; apply(s);
    s = idle(); s.mem_stall = 1; repeat (CMAX + 3) apply(s);
    s = idle(); s.ex_is_jump = 1; repeat (CMAX + 3) apply(s);
    s = idle(); s.trap_commit = 1; s.mem_stall = 1; apply(s);
    s.trap_commit = 0; s.rst = 1; apply(s);
    s = idle(); apply(s); apply(s);

    // Random traffic over a small register window so collisions are frequent
    for (int i = 0; i < 2500; i++) begin
      s = idle();
      s.rst           = pct(2);
      s.id_valid      = pct(80);
      s.id_need_rs1   = pct(60);
      s.id_need_rs2   = pct(50);
      s.id_reg_write  = pct(60);
      s.id_is_long    = pct(30);
      s.id_rs1 = raddr(); s.id_rs2 = raddr(); s.id_rd = raddr();
      s.ex_rs1 = raddr(); s.ex_rs2 = raddr(); s.ex_rd = raddr();
      s.ex_need_rs1   = pct(60);
      s.ex_need_rs2   = pct(50);
      s.ex_reg_write  = pct(60);
      s.ex_is_load    = pct(25);
      s.ex_is_csr     = pct(15);
      s.ex_is_branch  = pct(20);
      s.ex_br_taken   = pct(50);
      s.ex_is_jump    = pct(8);
      s.ex_is_mret    = pct(5);
      s.mem_rd = raddr(); s.wb_rd = raddr();
      s.mem_reg_write = pct(50);
      s.wb_reg_write  = pct(50);
      s.long_done     = pct(30);
      s.long_done_rd  = raddr();
      s.mem_stall     = pct(20);
      s.trap_commit   = pct(4);
      s.mret_commit   = pct(3);
      apply(s);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
